// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_con between N_REQ requesters, with a guard gap and a WAIT timeout.
// Build option: define SPI_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module spi_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 17,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_err,
  output logic [DATA_WIDTH-1:0]       spi_data_in,
  output logic                        spi_trigger,
  input  logic [DATA_WIDTH-1:0]       spi_data_out,
  input  logic                        spi_data_valid,
  input  logic                        spi_cs,
  output logic [N_REQ-1:0]            cs_n,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_idx
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GC_W  = 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_GUARD} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [DATA_WIDTH-1:0] spi_data_in_q, spi_data_in_d;
  logic                  spi_trigger_q, spi_trigger_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [GC_W-1:0]       guard_cnt_q, guard_cnt_d;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_any;

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        win_idx = IDX_W'(k);
        win_any = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  int               scan_j;

  // Scan upward from rr_ptr with wrap-around; the first asserted request wins.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    scan_j  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_j = int'(rr_ptr_q) + k;
      if (scan_j >= N_REQ) scan_j = scan_j - N_REQ;
      if (!win_any && req_valid[scan_j]) begin
        win_idx = IDX_W'(scan_j);
        win_any = 1'b1;
      end
    end
  end
`endif

  // Handshake: req_ready is high only for the winner and only in IDLE; a word is
  // taken on the clk edge where req_valid[i] && req_ready[i]. rsp_valid is a
  // one-cycle one-hot strobe with no back-pressure; rsp_data/rsp_err are qualified by it.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    spi_data_in_d = spi_data_in_q;
    spi_trigger_d = 1'b0;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = 1'b0;
    to_cnt_d      = to_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    req_ready     = '0;
    cs_n          = '1;
`ifndef SPI_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          req_ready[win_idx] = 1'b1;
          spi_data_in_d      = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_idx_d        = win_idx;
          spi_trigger_d      = 1'b1;
          to_cnt_d           = '0;
          state_d            = ST_LAUNCH;
`ifndef SPI_ARB_FIXED_PRIO_EN
          rr_ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      ST_LAUNCH: begin
        cs_n[grant_idx_q] = spi_cs;
        to_cnt_d          = '0;
        state_d           = ST_WAIT;
      end
      ST_WAIT: begin
        cs_n[grant_idx_q] = spi_cs;
        // Valid data takes precedence over a timeout expiring on the same cycle.
        if (spi_data_valid) begin
          rsp_data_d             = spi_data_out;
          rsp_valid_d[grant_idx_q] = 1'b1;
          guard_cnt_d            = '0;
          state_d                = ST_GUARD;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d             = '0;
          rsp_err_d              = 1'b1;
          rsp_valid_d[grant_idx_q] = 1'b1;
          guard_cnt_d            = '0;
          state_d                = ST_GUARD;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GC_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      spi_data_in_q <= '0;
      spi_trigger_q <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      to_cnt_q      <= '0;
      guard_cnt_q   <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      spi_data_in_q <= spi_data_in_d;
      spi_trigger_q <= spi_trigger_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      to_cnt_q      <= to_cnt_d;
      guard_cnt_q   <= guard_cnt_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign grant_idx   = grant_idx_q;
  assign spi_data_in = spi_data_in_q;
  assign spi_trigger = spi_trigger_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: table of whole transactions plus hand-written abort/stray sequences.
module tb_spi_arbiter;
  localparam int N  = 2;
  localparam int W  = 17;
  localparam int G  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [W-1:0]   spi_data_in;
  logic           spi_trigger;
  logic [W-1:0]   spi_data_out;
  logic           spi_data_valid;
  logic           spi_cs;
  logic [N-1:0]   cs_n;
  logic           busy;
  logic [0:0]     grant_idx;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0] mask;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int         resp_delay;  // WAIT cycle carrying spi_data_valid; -1 = never
    logic [W-1:0] resp_word;
    int         exp_grant;   // round-robin expectation
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  spi_arbiter #(
    .N_REQ(N), .DATA_WIDTH(W), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_data_in(spi_data_in), .spi_trigger(spi_trigger),
    .spi_data_out(spi_data_out), .spi_data_valid(spi_data_valid), .spi_cs(spi_cs),
    .cs_n(cs_n), .busy(busy), .grant_idx(grant_idx)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [1:0] all1;
    all1 = 2'b11;
    check({tag, "_busy"},   busy, 0);
    check({tag, "_grant"},  grant_idx, 0);
    check({tag, "_rspv"},   rsp_valid, 0);
    check({tag, "_rsperr"}, rsp_err, 0);
    check({tag, "_rspd"},   rsp_data, 0);
    check({tag, "_trig"},   spi_trigger, 0);
    check({tag, "_din"},    spi_data_in, 0);
    check({tag, "_csn"},    cs_n, all1);
    check({tag, "_ready"},  req_ready, 0);
  endtask

  // Driver: one full transaction, called at a negedge with the DUT idle.
  task automatic do_txn(input vec_t v, input int id);
    int g, cyc, gc, lat;
    logic [1:0] oh, csx, all1;
    logic [W-1:0] word, exp_word;
    all1 = 2'b11;
`ifdef SPI_ARB_FIXED_PRIO_EN
    g = v.mask[0] ? 0 : 1;
`else
    g = v.exp_grant;
`endif
    oh   = 2'b01 << g;
    csx  = ~oh;
    word = (g == 1) ? v.d1 : v.d0;
    req_data  = {v.d1, v.d0};
    req_valid = v.mask;
    #1;
    check($sformatf("t%0d_ready", id), req_ready, oh);
    check($sformatf("t%0d_trig_idle", id), spi_trigger, 0);
    @(negedge clk);
    req_valid = '0;
    spi_cs = 1'b0;
    #1;
    check($sformatf("t%0d_trigger", id), spi_trigger, 1);
    check($sformatf("t%0d_data_in", id), spi_data_in, word);
    check($sformatf("t%0d_grant", id), grant_idx, g);
    check($sformatf("t%0d_cs_launch", id), cs_n, csx);
    @(negedge clk);
    check($sformatf("t%0d_trig_pulse", id), spi_trigger, 0);
    check($sformatf("t%0d_cs_wait", id), cs_n, csx);
    check($sformatf("t%0d_busy", id), busy, 1);
    if (v.resp_delay >= 0 && v.resp_delay < TO) begin
      exp_q.push_back(v.resp_word);
      lat = v.resp_delay + 1;
    end else begin
      exp_q.push_back('0);
      lat = TO;
    end
    cyc = 0;
    spi_data_out = v.resp_word;
    while (rsp_valid == 0 && cyc < 64) begin
      spi_data_valid = (cyc == v.resp_delay);
      @(negedge clk);
      cyc++;
    end
    spi_data_valid = 1'b0;
    check($sformatf("t%0d_rsp_lat", id), cyc, lat);
    check($sformatf("t%0d_rsp_valid", id), rsp_valid, oh);
    check($sformatf("t%0d_rsp_err", id), rsp_err, v.exp_err);
    exp_word = exp_q.pop_front();
    check($sformatf("t%0d_rsp_data", id), rsp_data, exp_word);
    check($sformatf("t%0d_cs_guard", id), cs_n, all1);
    gc = 0;
    @(negedge clk);
    gc++;
    check($sformatf("t%0d_rsp_pulse", id), rsp_valid, 0);
    spi_data_valid = 1'b1;
    @(negedge clk);
    gc++;
    spi_data_valid = 1'b0;
    check($sformatf("t%0d_stray_guard", id), rsp_valid, 0);
    while (busy && gc < 20) begin
      @(negedge clk);
      gc++;
    end
    check($sformatf("t%0d_guard_len", id), gc, G);
    check($sformatf("t%0d_stray_guard_rsp", id), rsp_valid, 0);
    spi_cs = 1'b1;
  endtask

  // Start a transaction, reset the DUT mid-WAIT, then probe with a late valid.
  task automatic abort_seq(input logic [1:0] mask, input int g, input string tag);
    logic [1:0] oh, all1;
    all1 = 2'b11;
    oh = 2'b01 << g;
    req_data  = {17'h0_5A5A, 17'h1_2345};
    req_valid = mask;
    #1;
    check({tag, "_ready"}, req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    spi_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_in_wait"}, busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values(tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    spi_data_out   = 17'h1_7777;
    spi_data_valid = 1'b1;
    @(negedge clk);
    spi_data_valid = 1'b0;
    check({tag, "_late_rsp"}, rsp_valid, 0);
    check({tag, "_late_busy"}, busy, 0);
    check({tag, "_late_csn"}, cs_n, all1);
    @(negedge clk);
    check({tag, "_late_rsp2"}, rsp_valid, 0);
    spi_cs = 1'b1;
  endtask

  initial begin
    // Vector table: contention first (grants alternate from a fresh reset).
    vecs[0]  = '{2'b11, 17'h0_0101, 17'h0_0202, 0,  17'h0_1111, 0, 1'b0};
    vecs[1]  = '{2'b11, 17'h0_0303, 17'h0_0404, 1,  17'h0_2222, 1, 1'b0};
    vecs[2]  = '{2'b11, 17'h0_0505, 17'h0_0606, 3,  17'h0_3333, 0, 1'b0};
    vecs[3]  = '{2'b11, 17'h0_0707, 17'h0_0808, 2,  17'h0_4444, 1, 1'b0};
    vecs[4]  = '{2'b11, 17'h0_0909, 17'h0_0A0A, 5,  17'h0_5555, 0, 1'b0};
    vecs[5]  = '{2'b11, 17'h0_0B0B, 17'h0_0C0C, 0,  17'h0_6666, 1, 1'b0};
    vecs[6]  = '{2'b01, 17'h1_8000, 17'h0_0000, 2,  17'h0_03FF, 0, 1'b0};
    vecs[7]  = '{2'b10, 17'h0_0000, 17'h0_F00D, 4,  17'h1_ABCD, 1, 1'b0};
    vecs[8]  = '{2'b10, 17'h0_0000, 17'h1_0001, 0,  17'h0_0001, 1, 1'b0};
    vecs[9]  = '{2'b01, 17'h0_0DEF, 17'h0_0000, -1, 17'h1_5555, 0, 1'b1};
    vecs[10] = '{2'b11, 17'h0_1357, 17'h1_2468, 15, 17'h0_AAAA, 1, 1'b0};
    vecs[11] = '{2'b11, 17'h1_0F0F, 17'h0_F0F0, 14, 17'h1_FFFF, 0, 1'b0};

    // Reset block
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    spi_data_out = '0;
    spi_data_valid = 1'b0;
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    spi_cs = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) do_txn(vecs[i], i);

    // Abort granted to requester 1: grant_idx and data must clear.
    abort_seq(2'b10, 1, "abortA");
    // Abort granted to requester 0: the next contention must still go to 0.
    abort_seq(2'b01, 0, "abortB");
    do_txn('{2'b11, 17'h0_1234, 17'h0_4321, 1, 17'h0_0ACE, 0, 1'b0}, 12);

    // Stray spi_data_valid while idle.
    spi_cs = 1'b0;
    spi_data_out = 17'h0_BEEF;
    spi_data_valid = 1'b1;
    @(negedge clk);
    spi_data_valid = 1'b0;
    check("idle_stray_rsp", rsp_valid, 0);
    check("idle_stray_busy", busy, 0);
    check("idle_stray_csn", cs_n, 2'b11);
    @(negedge clk);
    check("idle_stray_rsp2", rsp_valid, 0);
    spi_cs = 1'b1;

    // Final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
